// File: rtl/vga_plot_arbiter_if.sv
// Pixel-producer / VGA-port bundle shared by the plot arbiter.
// Master side is the producers plus the VGA consumer; slave side is the arbiter.
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   lock;
  logic [8*NUM_REQ-1:0] req_x;
  logic [7*NUM_REQ-1:0] req_y;
  logic [3*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]   gnt;
  logic [7:0]           vga_x;
  logic [6:0]           vga_y;
  logic [2:0]           vga_colour;
  logic                 vga_plot;
  logic                 busy;

  modport master (
    output req, lock, req_x, req_y, req_colour,
    input  gnt, vga_x, vga_y, vga_colour,
    input  vga_plot, busy
  );

  modport slave (
    input  req, lock, req_x, req_y, req_colour,
    output gnt, vga_x, vga_y, vga_colour,
    output vga_plot, busy
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter with burst lock sharing one VGA pixel-write port.
// Optional macro VGA_PLOT_ARB_CLIP_EN suppresses off-screen plots.
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 64
) (
  input logic              clk,
  input logic              rst,
  vga_plot_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {ARB, GRANT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      last_q, last_d;
  logic [7:0]         hold_q, hold_d;
  logic [7:0]         x_q, x_d;
  logic [6:0]         y_q, y_d;
  logic [2:0]         c_q, c_d;
  logic               plot_q, plot_d;
  logic               busy_q, busy_d;

  logic [7:0]         x_sel;
  logic [6:0]         y_sel;
  logic [2:0]         c_sel;
  logic               req_cur;
  logic               lock_cur;
  logic               found;
  logic [IW-1:0]      win;
  logic [NUM_REQ-1:0] win_oh;
  logic               xfer;
  logic               last_hit;
  logic               rel;
  logic               clip;

  // In GRANT, last_q always names the current owner
  always_comb begin
    x_sel    = '0;
    y_sel    = '0;
    c_sel    = '0;
    req_cur  = 1'b0;
    lock_cur = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_q == IW'(i)) begin
        x_sel    = bus.req_x[i*8 +: 8];
        y_sel    = bus.req_y[i*7 +: 7];
        c_sel    = bus.req_colour[i*3 +: 3];
        req_cur  = bus.req[i];
        lock_cur = bus.lock[i];
      end
    end
  end

  // Scan above last_q first, then wrap; the owner itself comes last
  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && IW'(i) > last_q && bus.req[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && IW'(i) <= last_q && bus.req[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = (IW'(i) == win);
    end
  end

  assign xfer     = (state_q == GRANT) && req_cur;
  assign last_hit = (hold_q == 8'(MAX_HOLD - 1));
  assign rel      = !req_cur || (xfer && (!lock_cur || last_hit));

`ifdef VGA_PLOT_ARB_CLIP_EN
  assign clip = (x_sel >= 8'd160) || (y_sel >= 7'd120);
`else
  assign clip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    hold_d  = hold_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    plot_d  = 1'b0;

    if (xfer && !clip) begin
      plot_d = 1'b1;
      x_d    = x_sel;
      y_d    = y_sel;
      c_d    = c_sel;
    end

    unique case (state_q)
      ARB: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          last_d  = win;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          hold_d = '0;
          if (found) begin
            gnt_d  = win_oh;
            last_d = win;
          end else begin
            state_d = ARB;
            gnt_d   = '0;
          end
        end else if (xfer) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: ;
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      hold_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = c_q;
  assign bus.vga_plot   = plot_q;
  assign bus.busy       = busy_q;
endmodule
